// File: rtl/addsub_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addsub_pkg : shared types and constants for the nibble add/sub    |
// | Revision   : 1.0                                                  |
// +--------------------------------------------------------------------+
package addsub_pkg;

  localparam int NIB_W = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_addsub_slice.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nibble_addsub_slice : combinational 4-bit add/sub slice           |
// | Revision            : 1.0                                         |
// +--------------------------------------------------------------------+
module nibble_addsub_slice
  import addsub_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             mode,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout,
  output logic             c3
);

  logic [NIB_W-1:0] w_bx;
  logic [NIB_W-1:0] w_low;
  logic [1:0]       w_top;

  assign w_bx = b ^ {NIB_W{mode == MODE_SUB}};

  // Split at bit 3 so the carry into the MSB is visible for overflow.
  assign w_low = {1'b0, a[2:0]} + {1'b0, w_bx[2:0]} + {3'b000, cin};
  assign c3    = w_low[3];
  assign w_top = {1'b0, a[3]} + {1'b0, w_bx[3]} + {1'b0, c3};

  assign sum  = {w_top[0], w_low[2:0]};
  assign cout = w_top[1];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nibble_serial_addsub : multi-precision add/sub, one nibble/clock  |
// | Revision             : 1.0                                        |
// +--------------------------------------------------------------------+
module nibble_serial_addsub
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
)
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [NIB_W*NIBBLES-1:0] op_a,
  input  logic [NIB_W*NIBBLES-1:0] op_b,
  input  logic                     mode,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [NIB_W*NIBBLES-1:0] result,
  output logic                     carry_out,
  output logic                     overflow,
  output logic                     zero
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NIBBLES - 1);

  state_t           r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_mode;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;

  logic [NIB_W-1:0] w_sum;
  logic             w_cout;
  logic             w_c3;
  logic [W-1:0]     w_result_next;

  // Operand registers shift right each RUN cycle, so the active nibble is always at the bottom.
  nibble_addsub_slice u_slice (
    .a    (r_a[NIB_W-1:0]),
    .b    (r_b[NIB_W-1:0]),
    .mode (r_mode),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout),
    .c3   (w_c3)
  );

  always_comb begin
    w_result_next = result;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_result_next[i*NIB_W +: NIB_W] = w_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      result      <= '0;
      carry_out   <= 1'b0;
      overflow    <= 1'b0;
      zero        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_mode      <= 1'b0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a         <= op_a;
            r_b         <= op_b;
            r_mode      <= mode;
            r_carry     <= mode;
            r_idx       <= '0;
            start_ready <= 1'b0;
            r_state     <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> NIB_W;
          r_b     <= r_b >> NIB_W;
          result  <= w_result_next;
          r_carry <= w_cout;
          r_idx   <= r_idx + IDX_W'(1);
          if (r_idx == c_last_idx) begin
            carry_out <= w_cout;
            overflow  <= w_c3 ^ w_cout;
            zero      <= (w_result_next == '0);
            res_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
Multi-precision adder/subtractor that processes 4*NIBBLES-bit operands one nibble per clock, LSB nibble first, propagating carry between nibbles.
Sits upstream of the 4-bit adder/subtractor datapath in the same domain. It extends the same add/sub semantics (M=1 means A + ~B + 1) to wider words.
Operands enter through a valid/ready request port. The result and flags leave through a valid/ready response port.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand (operand width W = 4*NIBBLES); legal range 1..16

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start_valid  input  1  request: operands and mode valid
start_ready  output  1  block can accept a request
op_a  input  W  operand A
op_b  input  W  operand B
mode  input  1  0 = add (A+B), 1 = subtract (A-B)
res_valid  output  1  result and flags valid
res_ready  input  1  consumer accepts result
result  output  W  sum/difference
carry_out  output  1  carry out of MSB; in subtract mode 1 = no borrow (A >= B unsigned)
overflow  output  1  two's-complement signed overflow
zero  output  1  result == 0

Behaviour:
- Reset (async assert, sync release): state=IDLE; start_ready=1; res_valid=0; result=0; carry_out=0; overflow=0; zero=0. Internal index and carry cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - When start_valid & start_ready at a rising edge: latch op_a, op_b and mode; set carry register = mode; set nibble index = 0; go to RUN.
  - result and flags keep their previous values until that acceptance edge.
- RUN:
  - start_ready=0.
  - Each cycle, nibble i = a[4i+3:4i] + (b[4i+3:4i] XOR {4{mode}}) + carry.
  - The 4-bit sum is written into result[4i+3:4i]. The nibble carry-out updates the carry register. Index increments.
  - On the last nibble (i = NIBBLES-1):
    - carry_out = final carry.
    - overflow = carry into bit W-1 XOR carry out of bit W-1.
    - zero = (full result == 0), evaluated on the completed word.
    - Go to DONE.
- DONE:
  - res_valid=1; start_ready=0.
  - result and flags are held stable while res_ready=0.
  - On res_valid & res_ready: return to IDLE; res_valid falls at that edge.
- Latency: exactly NIBBLES cycles from the acceptance edge to the edge that raises res_valid. Throughput is one operation per NIBBLES+2 cycles minimum (DONE and IDLE each take at least one cycle).
- start_valid while not in IDLE is ignored; no queuing. Operand inputs are don't-care outside the acceptance edge.
- Result handshake and new request cannot share a cycle: the next request is accepted no earlier than the first IDLE cycle.
- Wrap-around: modulo-2^W arithmetic, e.g. 0xFFFF+1 = 0x0000 with carry_out=1.
- Reset mid-RUN or mid-DONE: partial result discarded; all outputs return to reset values immediately; res_valid never glitches high.
- NIBBLES=1 degenerates to a one-cycle 4-bit add/sub with identical carry semantics to the 4-bit adder/subtractor.

Decomposition:
- Shared package addsub_pkg holds:
  - State enum: IDLE, RUN, DONE.
  - Constants MODE_ADD=1'b0 and MODE_SUB=1'b1.
  - Localparam NIB_W=4.
- One sub-module, nibble_addsub_slice: combinational 4-bit slice.
  - Inputs: a, b, mode, cin.
  - Outputs: sum[3:0], cout, c3. c3 is the carry into bit 3, used for overflow on the last nibble.
- The top level contains the FSM, nibble index counter, carry register, operand registers and result register.

Test Plan:
- NIBBLES=4, add 0x1234 + 0x0FFF -> after 4 cycles res_valid=1, result=0x2233, carry_out=0, overflow=0, zero=0.
- Subtract 0x0005 - 0x0009 -> result=0xFFFC, carry_out=0 (borrow), overflow=0. Subtract 0x8000 - 0x0001 -> result=0x7FFF, carry_out=1, overflow=1.
- Add 0x7FFF + 0x0001 -> result=0x8000, overflow=1, carry_out=0. Add 0xFFFF + 0x0001 -> result=0x0000, carry_out=1, zero=1, overflow=0.
- Backpressure: hold res_ready=0 for 5 cycles in DONE while toggling start_valid and operands -> result/flags stable, start_ready=0, no new acceptance. Then res_ready=1 -> IDLE next cycle, start_ready=1.
- Reset mid-operation: accept 0x1111+0x2222, assert rst_n=0 after 2 RUN cycles -> res_valid=0, result=0 immediately. After release, a new 0x0001+0x0001 yields 0x0002 with latency 4.
- NIBBLES=1 instance:
  - 9 - 5 -> result=4, carry_out=1.
  - 12 + 12 -> result=8, carry_out=1.
  - 0 - 15 -> result=1, carry_out=0.
